// File: rtl/sp_ram_arb_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
package sp_ram_arb_pkg;

    // Which master owns the response slot in the cycle after a grant.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_e;

    // RAM read data arrives this many cycles after the access strobe.
    localparam int RAM_RD_LATENCY = 1;

endpackage

// File: rtl/sp_ram_arb_sel.sv
// Two-input arbitration cell: turns req[1:0] into a one-hot grant.
// Macro SP_RAM_ARB_ROUND_ROBIN_EN selects round-robin (defined) or fixed
// M0-first priority (undefined, default).
module sp_ram_arb_sel (
    input  logic [1:0] req,
    input  logic       last,   // 0 = M0 was granted most recently, 1 = M1
    output logic [1:0] gnt
);

`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
    // Round-robin: on conflict the port that did not win last time goes next.
    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end
`else
    // The history input has no meaning under fixed priority.
    logic unused_last;
    assign unused_last = last;

    // Fixed priority: M0 always wins, M1 only gets idle M0 cycles.
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/sp_ram_arbiter.sv
// Shares one single-port RAM between two PULP-style masters.
// Macro SP_RAM_ARB_ROUND_ROBIN_EN enables round-robin arbitration; without it
// M0 has fixed priority and no history register exists.
//
// Handshake: a master raises req with stable attributes and holds them until
// gnt is seen high in the same cycle; that cycle is the RAM access. Exactly one
// cycle later rvalid pulses on the same port (reads and writes alike) with
// rdata valid for reads. A new grant may coincide with an rvalid.
module sp_ram_arbiter
    import sp_ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_i,
    input  logic                    m0_req_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_gnt_o,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    input  logic                    m1_req_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_gnt_o,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
    output owner_e                  dbg_own_o
);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       last_sel;
    owner_e     own_q;
    owner_e     own_d;

    // Requests are masked during reset so no access is launched.
    assign req = {m1_req_i, m0_req_i} & {2{~rst_i}};

`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Remember the most recently granted port; idle cycles keep history.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else if (|gnt) begin
            last_q <= gnt[1];
        end
    end

    assign last_sel = last_q;
`else
    assign last_sel = 1'b1;
`endif

    sp_ram_arb_sel u_sel (
        .req  (req),
        .last (last_sel),
        .gnt  (gnt)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];

    // Attribute mux: forward the granted master, drive zeros when idle.
    always_comb begin
        ram_en_o    = |gnt;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_be_o    = '0;
        ram_wdata_o = '0;
        if (gnt[0]) begin
            ram_addr_o  = m0_addr_i;
            ram_we_o    = m0_we_i;
            ram_be_o    = m0_be_i;
            ram_wdata_o = m0_wdata_i;
        end else if (gnt[1]) begin
            ram_addr_o  = m1_addr_i;
            ram_we_o    = m1_we_i;
            ram_be_o    = m1_be_i;
            ram_wdata_o = m1_wdata_i;
        end
    end

    // Next response owner is whoever is granted this cycle.
    always_comb begin
        own_d = OWN_NONE;
        if (gnt[0]) begin
            own_d = OWN_M0;
        end else if (gnt[1]) begin
            own_d = OWN_M1;
        end
    end

    // Owner register; reset drops any response still in flight.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            own_q <= OWN_NONE;
        end else begin
            own_q <= own_d;
        end
    end

    assign dbg_own_o = own_q;

    // Response demux: steer RAM read data to the owning port only.
    always_comb begin
        m0_rvalid_o = (own_q == OWN_M0) && !rst_i;
        m1_rvalid_o = (own_q == OWN_M1) && !rst_i;
        m0_rdata_o  = m0_rvalid_o ? ram_rdata_i : '0;
        m1_rdata_o  = m1_rvalid_o ? ram_rdata_i : '0;
    end

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// Self-checking bench for sp_ram_arbiter: directed scenarios plus a random
// two-master run, checked against a transaction-level model and a RAM model.
module tb_sp_ram_arbiter;
    import sp_ram_arb_pkg::*;

    localparam int AW    = 15;
    localparam int DW    = 32;
    localparam int BW    = DW / 8;
    localparam int WORDS = 1 << (AW - 2);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    // ---------------- master-side stimulus ----------------
    logic [1:0]    req;
    logic [AW-1:0] addr  [2];
    logic [1:0]    we;
    logic [BW-1:0] be    [2];
    logic [DW-1:0] wdata [2];

    logic          m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [DW-1:0] m0_rdata_o, m1_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [BW-1:0] ram_be_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i;
    owner_e        dbg_own;

    sp_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_i       (rst_i),
        .m0_req_i    (req[0]),
        .m0_addr_i   (addr[0]),
        .m0_we_i     (we[0]),
        .m0_be_i     (be[0]),
        .m0_wdata_i  (wdata[0]),
        .m0_gnt_o    (m0_gnt_o),
        .m0_rvalid_o (m0_rvalid_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (req[1]),
        .m1_addr_i   (addr[1]),
        .m1_we_i     (we[1]),
        .m1_be_i     (be[1]),
        .m1_wdata_i  (wdata[1]),
        .m1_gnt_o    (m1_gnt_o),
        .m1_rvalid_o (m1_rvalid_o),
        .m1_rdata_o  (m1_rdata_o),
        .ram_en_o    (ram_en_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_be_o    (ram_be_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .dbg_own_o   (dbg_own)
    );

    // ---------------- RAM model (stands in for sp_ram_wrap) ----------------
    logic [DW-1:0] ram_mem [WORDS];
    logic [DW-1:0] ref_mem [WORDS];

    always @(posedge clk) begin
        logic [DW-1:0] word;
        if (ram_en_o && !ram_we_o) begin
            ram_rdata_i <= ram_mem[ram_addr_o[AW-1:2]];
        end else begin
            ram_rdata_i <= $urandom;   // junk when no read is pending
        end
        if (ram_en_o && ram_we_o) begin
            word = ram_mem[ram_addr_o[AW-1:2]];
            for (int b = 0; b < BW; b++) begin
                if (ram_be_o[b]) word[8*b +: 8] = ram_wdata_o[8*b +: 8];
            end
            ram_mem[ram_addr_o[AW-1:2]] <= word;
        end
    end

    // ---------------- scoreboard / reference model ----------------
    // Entry: {is_read, rvalid one-hot {m1,m0}, read data}; head = this cycle.
    logic [DW+2:0] exp_q[$];
    int            exp_last;   // port granted most recently (round-robin)
    int            checks = 0;
    int            errors = 0;

    // Which port the arbiter should grant given the current inputs.
    function automatic int model_grant();
        if (rst_i) return -1;
        if (req == 2'b11) begin
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
            return (exp_last == 0) ? 1 : 0;
`else
            return 0;
`endif
        end
        if (req[0]) return 0;
        if (req[1]) return 1;
        return -1;
    endfunction

    // Apply this cycle's access to the model, then move to the next cycle.
    task automatic advance(output int g);
        logic [DW+2:0] e;
        logic [AW-3:0] idx;
        g = model_grant();
        void'(exp_q.pop_front());
        e = '0;
        if (g >= 0) begin
            idx = addr[g][AW-1:2];
            e[DW+1:DW] = (g == 0) ? 2'b01 : 2'b10;
            if (we[g]) begin
                for (int b = 0; b < BW; b++) begin
                    if (be[g][b]) ref_mem[idx][8*b +: 8] = wdata[g][8*b +: 8];
                end
            end else begin
                e[DW+2]   = 1'b1;
                e[DW-1:0] = ref_mem[idx];
            end
        end
        exp_q.push_back(e);
        if (rst_i) exp_last = 1;
        else if (g >= 0) exp_last = g;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_m(input int p, input logic r, input logic [AW-1:0] a,
                         input logic w, input logic [BW-1:0] b, input logic [DW-1:0] d);
        req[p]   = r;
        addr[p]  = a;
        we[p]    = w;
        be[p]    = b;
        wdata[p] = d;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int g;
        set_m(0, 1'b1, 15'h0010, 1'b0, 4'hF, '0);
        set_m(1, 1'b1, 15'h0020, 1'b0, 4'hF, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m1_gnt_o, m0_gnt_o, m1_rvalid_o, m0_rvalid_o, ram_en_o} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl cyc %0d got gnt=%b%b rv=%b%b en=%b want all 0",
                         i, m1_gnt_o, m0_gnt_o, m1_rvalid_o, m0_rvalid_o, ram_en_o);
            end
            checks++;
            if ({ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o, m0_rdata_o, m1_rdata_o} !== '0) begin
                errors++;
                $display("FAIL reset_data cyc %0d addr=%h be=%h wd=%h rd0=%h rd1=%h want 0",
                         i, ram_addr_o, ram_be_o, ram_wdata_o, m0_rdata_o, m1_rdata_o);
            end
            advance(g);
        end
        rst_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({m1_gnt_o, m0_gnt_o} !== 2'b01) begin
            errors++;
            $display("FAIL reset_first_gnt got %b%b want 01", m1_gnt_o, m0_gnt_o);
        end
        advance(g);
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({m1_gnt_o, m0_gnt_o, m0_rvalid_o} !== 3'b101) begin
            errors++;
            $display("FAIL reset_second got gnt=%b%b m0_rv=%b want gnt=10 rv=1",
                     m1_gnt_o, m0_gnt_o, m0_rvalid_o);
        end
        checks++;
        if (m0_rdata_o !== exp_q[0][DW-1:0]) begin
            errors++;
            $display("FAIL reset_first_rdata got %h want %h", m0_rdata_o, exp_q[0][DW-1:0]);
        end
        advance(g);
        req[1] = 1'b0;
    endtask

    task automatic test_write_read();
        int g;
        set_m(0, 1'b1, 15'h0040, 1'b1, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        checks++;
        if ({m0_gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o}
            !== {3'b111, 15'h0040, 4'hF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL wr_access got gnt=%b en=%b we=%b a=%h be=%h wd=%h want 1 1 1 0040 f deadbeef",
                     m0_gnt_o, ram_en_o, ram_we_o, ram_addr_o, ram_be_o, ram_wdata_o);
        end
        advance(g);
        set_m(0, 1'b1, 15'h0040, 1'b0, 4'hF, '0);
        @(negedge clk);
        checks++;
        if ({m0_rvalid_o, m0_gnt_o, ram_we_o} !== 3'b110) begin
            errors++;
            $display("FAIL wr_rvalid got rv=%b gnt=%b we=%b want 1 1 0", m0_rvalid_o, m0_gnt_o, ram_we_o);
        end
        advance(g);
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid_o, m0_rdata_o, ram_en_o} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            errors++;
            $display("FAIL rd_back got rv=%b rd=%h en=%b want 1 deadbeef 0", m0_rvalid_o, m0_rdata_o, ram_en_o);
        end
        advance(g);
    endtask

    task automatic test_contention();
        int g;
        int exp_g;
        int prev;
        rst_i = 1'b1;
        advance(g);
        rst_i = 1'b0;
        set_m(0, 1'b1, 15'h0100, 1'b0, 4'hF, '0);
        set_m(1, 1'b1, 15'h0200, 1'b0, 4'hF, '0);
        prev = -1;
        for (int i = 0; i < 6; i++) begin
`ifdef SP_RAM_ARB_ROUND_ROBIN_EN
            exp_g = i % 2;
`else
            exp_g = 0;
`endif
            @(negedge clk);
            checks++;
            if ({m1_gnt_o, m0_gnt_o} !== ((exp_g == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL cont_gnt cyc %0d got %b%b want port %0d", i, m1_gnt_o, m0_gnt_o, exp_g);
            end
            if (prev >= 0) begin
                checks++;
                if ({m1_rvalid_o, m0_rvalid_o} !== ((prev == 0) ? 2'b01 : 2'b10)
                    || (prev == 0 ? m0_rdata_o : m1_rdata_o) !== exp_q[0][DW-1:0]) begin
                    errors++;
                    $display("FAIL cont_resp cyc %0d got rv=%b%b rd0=%h rd1=%h want port %0d data %h",
                             i, m1_rvalid_o, m0_rvalid_o, m0_rdata_o, m1_rdata_o, prev, exp_q[0][DW-1:0]);
                end
            end
            prev = exp_g;
            advance(g);
        end
        req[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({m1_gnt_o, m0_gnt_o} !== 2'b10) begin
            errors++;
            $display("FAIL cont_m1_after_drop got %b%b want 10", m1_gnt_o, m0_gnt_o);
        end
        checks++;
        if ({m1_rvalid_o, m0_rvalid_o} !== ((prev == 0) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL cont_last_resp got %b%b want port %0d", m1_rvalid_o, m0_rvalid_o, prev);
        end
        advance(g);
        req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({m1_rvalid_o, m1_rdata_o} !== {1'b1, ref_mem[15'h0200 >> 2]}) begin
            errors++;
            $display("FAIL cont_m1_data got rv=%b rd=%h want 1 %h", m1_rvalid_o, m1_rdata_o, ref_mem[15'h0200 >> 2]);
        end
        advance(g);
    endtask

    task automatic test_byte_enable();
        int g;
        set_m(1, 1'b1, 15'h0000, 1'b1, 4'h5, 32'h11223344);
        @(negedge clk);
        checks++;
        if ({m1_gnt_o, ram_be_o, ram_wdata_o} !== {1'b1, 4'h5, 32'h11223344}) begin
            errors++;
            $display("FAIL be_pass got gnt=%b be=%h wd=%h want 1 5 11223344", m1_gnt_o, ram_be_o, ram_wdata_o);
        end
        advance(g);
        set_m(1, 1'b1, 15'h0000, 1'b0, 4'hF, '0);
        @(negedge clk);
        advance(g);
        req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if ({m1_rvalid_o, m1_rdata_o, m0_rvalid_o, m0_rdata_o} !== {1'b1, 32'h00220044, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL be_readback got rv1=%b rd1=%h rv0=%b rd0=%h want 1 00220044 0 0",
                     m1_rvalid_o, m1_rdata_o, m0_rvalid_o, m0_rdata_o);
        end
        advance(g);
    endtask

    task automatic test_reset_mid();
        int g;
        set_m(1, 1'b1, 15'h0008, 1'b0, 4'hF, '0);
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({m1_gnt_o, ram_en_o} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_gnt got gnt=%b en=%b want 0 0", m1_gnt_o, ram_en_o);
        end
        advance(g);
        rst_i  = 1'b0;
        req[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (m1_rvalid_o !== 1'b0 || dbg_own !== OWN_NONE) begin
            errors++;
            $display("FAIL rstmid_resp got rv=%b own=%0d want 0 0", m1_rvalid_o, dbg_own);
        end
        advance(g);
    endtask

    task automatic test_random();
        int            g;
        int            gp;
        logic [1:0]    exp_gnt;
        logic [DW+2:0] e;
        logic [DW-1:0] exp_rd [2];
        gp = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!req[p] || gp == p) begin
                    set_m(p, ($urandom_range(0, 3) != 0), AW'($urandom_range(0, 31)) << 2,
                          1'($urandom_range(0, 1)), BW'($urandom_range(1, 15)), $urandom);
                end
            end
            @(negedge clk);
            g = model_grant();
            exp_gnt = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
            checks++;
            if ({m1_gnt_o, m0_gnt_o} !== exp_gnt || ram_en_o !== (g >= 0)) begin
                errors++;
                $display("FAIL rand_gnt cyc %0d got gnt=%b%b en=%b want %b", cyc, m1_gnt_o, m0_gnt_o, ram_en_o, exp_gnt);
            end
            checks++;
            if (g >= 0) begin
                if ({ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o} !== {addr[g], we[g], be[g], wdata[g]}) begin
                    errors++;
                    $display("FAIL rand_attr cyc %0d got a=%h we=%b be=%h wd=%h want port %0d a=%h",
                             cyc, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o, g, addr[g]);
                end
            end else if ({ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o} !== '0) begin
                errors++;
                $display("FAIL rand_idle cyc %0d got a=%h we=%b be=%h wd=%h want 0",
                         cyc, ram_addr_o, ram_we_o, ram_be_o, ram_wdata_o);
            end
            e = exp_q[0];
            for (int p = 0; p < 2; p++) begin
                exp_rd[p] = e[DW+p] ? (e[DW+2] ? e[DW-1:0] : ram_rdata_i) : '0;
            end
            checks++;
            if ({m1_rvalid_o, m0_rvalid_o} !== e[DW+1:DW]
                || m0_rdata_o !== exp_rd[0] || m1_rdata_o !== exp_rd[1]) begin
                errors++;
                $display("FAIL rand_resp cyc %0d got rv=%b%b rd0=%h rd1=%h want rv=%b rd0=%h rd1=%h",
                         cyc, m1_rvalid_o, m0_rvalid_o, m0_rdata_o, m1_rdata_o,
                         e[DW+1:DW], exp_rd[0], exp_rd[1]);
            end
            advance(gp);
        end
        req = 2'b00;
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        for (int i = 0; i < WORDS; i++) begin
            ram_mem[i] = DW'(i) * 32'h9E3779B1;
            ref_mem[i] = DW'(i) * 32'h9E3779B1;
        end
        rst_i = 1'b1;
        req   = 2'b00;
        set_m(0, 1'b0, '0, 1'b0, '0, '0);
        set_m(1, 1'b0, '0, 1'b0, '0, '0);
        exp_q.push_back('0);
        exp_last = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_contention();
        test_byte_enable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sp_ram_arbiter.md
# sp_ram_arbiter

Two-port arbiter that shares one single-port data/instruction RAM macro (`sp_ram_wrap`) between two bus masters, e.g. the core data port and the SPI/debug loader. The arbiter picks one request per cycle and drives the RAM's enable, address, write-data and byte-enable lines. One cycle later it returns `rvalid` and read data to the master that was granted. It sits directly in front of `sp_ram_wrap`, with the master-side ports using the PULP req/gnt/rvalid protocol.

## Interface
- `ADDR_WIDTH`, default 15: byte-address width; matches the RAM wrapper.
- `DATA_WIDTH`, default 32: data width; byte enables are `DATA_WIDTH/8`.
- `clk`, in, 1: single clock for all logic.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `mN_req_i` (N=0,1), in, 1: request; held with its attributes until `mN_gnt_o`.
- `mN_addr_i`, in, ADDR_WIDTH: byte address.
- `mN_we_i`, in, 1: 1 = write, 0 = read.
- `mN_be_i`, in, DATA_WIDTH/8: byte enables.
- `mN_wdata_i`, in, DATA_WIDTH: write data.
- `mN_gnt_o`, out, 1: request accepted this cycle (combinational from req and arbitration state).
- `mN_rvalid_o`, out, 1: response valid, one cycle after grant; asserted for both reads and writes.
- `mN_rdata_o`, out, DATA_WIDTH: read data; meaningful only while `mN_rvalid_o` is high.
- `ram_en_o`, out, 1: RAM access strobe.
- `ram_addr_o`, out, ADDR_WIDTH: muxed address.
- `ram_we_o`, out, 1: muxed write enable.
- `ram_be_o`, out, DATA_WIDTH/8: muxed byte enables.
- `ram_wdata_o`, out, DATA_WIDTH: muxed write data.
- `ram_rdata_i`, in, DATA_WIDTH: RAM read data, valid one cycle after `ram_en_o`.

## Operation
- Per cycle, at most one grant. `ram_en_o` = `m0_gnt_o | m1_gnt_o`, and the `ram_*` outputs carry the granted master's attributes.
- When no master is granted, the `ram_*` outputs are 0.
- **Single request:** granted immediately, regardless of history.
- **Both request, round-robin:** the port not recorded in the `last` register wins.
  - `last` updates to the granted port on every grant.
  - `last` is unchanged in idle cycles.
- **Response state:** an owner register (`own_q`: NONE/M0/M1) records the granted port, one entry deep.
- **Response cycle:**
  - `mN_rvalid_o` = (`own_q` == MN).
  - `mN_rdata_o` = `ram_rdata_i` when `own_q` == MN, else 0.
- **Back-to-back:** a grant in the same cycle as an `rvalid` is legal. There is full throughput of one access per cycle with no bubbles.
- **Master rule:** a master does not deassert `req` or change attributes before `gnt`. The arbiter does not check this.
- **Reset values, held while `rst_i` is high:**
  - `own_q` = NONE.
  - `last` = M1, so M0 wins the first conflict.
  - All `gnt`, `rvalid` and `ram_en_o` outputs are 0.
  - All data outputs are 0.
- **Reset asserted in a grant cycle:** that access's response is discarded; no `rvalid` appears the next cycle.

## Timing
- Cycle T: `req` high and selected, so `gnt` is high in T and `ram_en_o` is high in T.
- Cycle T+1: `rvalid` is high for that master and `ram_rdata_i` is forwarded.
- Latency from request to grant is 0 cycles when uncontested.
- Under continuous contention, each master is granted at most every 2nd cycle (round-robin).
- `gnt` is combinational from `req`. No combinational path from `ram_rdata_i` to any `gnt`.

## Configuration
- Macro: `SP_RAM_ARB_ROUND_ROBIN_EN`.
- **Defined:** round-robin arbitration as above, using the `last` register.
- **Undefined:** fixed priority, M0 always wins on conflict. The `last` register is not instantiated, and M1 is granted only in cycles where `m0_req_i` is 0.

## Structure
- **Package `sp_ram_arb_pkg`:**
  - `owner_e` enum {OWN_NONE, OWN_M0, OWN_M1}.
  - Constant `RAM_RD_LATENCY` = 1.
- **Sub-module `sp_ram_arb_sel`:** 2-input arbitration cell.
  - Inputs: `req[1:0]` and `last`.
  - Outputs: one-hot `gnt[1:0]`.
  - Contains the macro-selected policy.
- **Top level:** contains the attribute mux, the `last`/`own_q` registers and the response demux.

## Test plan
- **Reset:** hold `rst_i` 3 cycles with both `req` high → all `gnt`/`rvalid`/`ram_en_o` are 0; after release, M0 is granted first.
- **Single write then read:**
  - M0 writes 0xDEADBEEF to 0x40 with be=0xF → `m0_rvalid_o` the next cycle.
  - M0 then reads 0x40 → `m0_rdata_o` = 0xDEADBEEF one cycle after grant.
- **Contention, macro defined:** both masters request reads continuously for 6 cycles → grants alternate M0, M1, M0, M1, M0, M1, and each `rvalid` lands on the matching port at T+1.
- **Contention, macro undefined:** same stimulus → M0 granted every cycle and M1 never; after M0 drops `req`, M1 is granted the same cycle.
- **Byte-enable passthrough:** M1 writes 0x11223344 with be=0x5 over 0x0 → RAM sees `ram_be_o` = 0x5, and a read back returns 0x00220044.
- **Reset mid-access:** assert `rst_i` in M1's grant cycle → `m1_rvalid_o` stays 0 the next cycle and `own_q` = NONE.
